// File: rtl/ps2_kbd_rx.sv
// ps2_kbd_rx: PS/2 keyboard receiver with a show-ahead scan-code FIFO.
// Raw pads are synchronized, the clock pad is glitch-filtered, 11-bit frames
// are deframed and checked, and good bytes are queued for the CPU. One
// status/data word exposes the head byte, fill level and sticky error flags.
module ps2_kbd_rx #(
  parameter int FILTER  = 8,      // consecutive equal samples before the filtered clock moves
  parameter int TIMEOUT = 20000,  // idle cycles mid-frame before the frame is abandoned
  parameter int DEPTH   = 8       // FIFO entries, power of 2, at most 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  input  logic        rd,
  output logic [31:0] data_out,
  output logic        ready
);

  localparam int FW = $clog2(FILTER + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_t;

  // ---------------------------------------------------------------------
  // Input synchronizers and clock filter
  // ---------------------------------------------------------------------
  logic [1:0]    sync1_reg;      // [0] = ps2_clk, [1] = ps2_data
  logic [1:0]    sync2_reg;
  logic          clk_s;
  logic          data_s;
  logic          filt_clk_reg;
  logic          filt_prev_reg;
  logic [FW-1:0] filt_cnt_reg;
  logic          sample_pulse;

  assign clk_s  = sync2_reg[0];
  assign data_s = sync2_reg[1];

  // Two-flop synchronizers on both pads; idle level of a PS/2 line is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_reg <= 2'b11;
      sync2_reg <= 2'b11;
    end else begin
      sync1_reg <= {ps2_data, ps2_clk};
      sync2_reg <= sync1_reg;
    end
  end

  // The filtered clock follows the synchronized clock only after FILTER
  // consecutive samples disagree with it, so short glitches are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_clk_reg  <= 1'b1;
      filt_prev_reg <= 1'b1;
      filt_cnt_reg  <= '0;
    end else begin
      filt_prev_reg <= filt_clk_reg;
      if (clk_s != filt_clk_reg) begin
        if (filt_cnt_reg == FW'(FILTER - 1)) begin
          filt_clk_reg <= clk_s;
          filt_cnt_reg <= '0;
        end else begin
          filt_cnt_reg <= filt_cnt_reg + FW'(1);
        end
      end else begin
        filt_cnt_reg <= '0;
      end
    end
  end

  // One-cycle pulse on each falling edge of the filtered clock; both terms
  // are registers, so the pulse is glitch-free.
  assign sample_pulse = filt_prev_reg & ~filt_clk_reg;

  // ---------------------------------------------------------------------
  // Deframer
  // ---------------------------------------------------------------------
  state_t        state_reg, state_next;
  logic [7:0]    shift_reg, shift_next;
  logic [2:0]    bit_cnt_reg, bit_cnt_next;
  logic          parity_reg, parity_next;
  logic [TW-1:0] to_cnt_reg, to_cnt_next;
  logic          push_reg, push_next;
  logic          err_set_reg, err_set_next;

  // Deframer state and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      shift_reg   <= '0;
      bit_cnt_reg <= '0;
      parity_reg  <= 1'b0;
      to_cnt_reg  <= '0;
      push_reg    <= 1'b0;
      err_set_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      shift_reg   <= shift_next;
      bit_cnt_reg <= bit_cnt_next;
      parity_reg  <= parity_next;
      to_cnt_reg  <= to_cnt_next;
      push_reg    <= push_next;
      err_set_reg <= err_set_next;
    end
  end

  // Frame walk: start, 8 data bits LSB first, odd parity, stop. A good frame
  // raises push for one cycle; a bad one raises err_set. The shift register
  // holds the byte until the next start bit, so it doubles as FIFO write data.
  always_comb begin
    state_next   = state_reg;
    shift_next   = shift_reg;
    bit_cnt_next = bit_cnt_reg;
    parity_next  = parity_reg;
    to_cnt_next  = to_cnt_reg;
    push_next    = 1'b0;
    err_set_next = 1'b0;

    if (sample_pulse || (state_reg == ST_IDLE)) begin
      to_cnt_next = '0;
    end else begin
      to_cnt_next = to_cnt_reg + TW'(1);
    end

    case (state_reg)
      ST_IDLE: begin
        if (sample_pulse && !data_s) begin
          shift_next   = '0;
          bit_cnt_next = '0;
          state_next   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (sample_pulse) begin
          shift_next   = {data_s, shift_reg[7:1]};
          bit_cnt_next = bit_cnt_reg + 3'd1;
          if (bit_cnt_reg == 3'd7) begin
            state_next = ST_PARITY;
          end
        end
      end
      ST_PARITY: begin
        if (sample_pulse) begin
          parity_next = data_s;
          state_next  = ST_STOP;
        end
      end
      ST_STOP: begin
        if (sample_pulse) begin
          state_next = ST_IDLE;
          if ((^shift_reg ^ parity_reg) && data_s) begin
            push_next = 1'b1;
          end else begin
            err_set_next = 1'b1;
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // A stalled frame is abandoned silently; err is not touched.
    if ((state_reg != ST_IDLE) && !sample_pulse && (to_cnt_reg == TW'(TIMEOUT - 1))) begin
      state_next  = ST_IDLE;
      to_cnt_next = '0;
    end
  end

  // ---------------------------------------------------------------------
  // Scan-code FIFO and status flags
  // ---------------------------------------------------------------------
  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [3:0]    count_reg;
  logic [3:0]    count_next;
  logic          overflow_reg;
  logic          err_reg;
  logic          full;
  logic          do_pop;
  logic          do_push;
  logic          ovf_set;
  logic [DEPTH-1:0] wr_sel;
  logic [7:0]    head;

  assign full    = (count_reg == 4'(DEPTH));
  assign do_pop  = rd && (count_reg != 4'd0);
  assign do_push = push_reg && (!full || do_pop);
  assign ovf_set = push_reg && full && !do_pop;

  // One-hot write select per storage entry.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_wr_sel
      assign wr_sel[gi] = do_push && (wr_ptr_reg == PW'(gi));
    end
  endgenerate

  // Fill level: simultaneous push and pop leave it unchanged.
  always_comb begin
    count_next = count_reg;
    case ({do_push, do_pop})
      2'b10:   count_next = count_reg + 4'd1;
      2'b01:   count_next = count_reg - 4'd1;
      default: count_next = count_reg;
    endcase
  end

  // Pointers, count and sticky flags; a flag set in the rd cycle wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= (wr_ptr_reg == PW'(DEPTH - 1)) ? '0 : wr_ptr_reg + PW'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= (rd_ptr_reg == PW'(DEPTH - 1)) ? '0 : rd_ptr_reg + PW'(1);
      end
      count_reg <= count_next;

      if (ovf_set) begin
        overflow_reg <= 1'b1;
      end else if (rd) begin
        overflow_reg <= 1'b0;
      end

      if (err_set_reg) begin
        err_reg <= 1'b1;
      end else if (rd) begin
        err_reg <= 1'b0;
      end
    end
  end

  // Byte storage; contents need no reset because the head is masked when empty.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_sel[i]) begin
        mem[i] <= shift_reg;
      end
    end
  end

  // Status word built from registers only; rd never reaches it combinationally.
  assign ready    = (count_reg != 4'd0);
  assign head     = ready ? mem[rd_ptr_reg] : 8'h00;
  assign data_out = {16'h0000, count_reg, 1'b0, err_reg, overflow_reg, ready, head};

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Directed testbench for ps2_kbd_rx: drives PS/2 frames on the pads and
// checks the status/data word against hand-computed values.
module tb_ps2_kbd_rx;

  localparam int HALF    = 30;    // PS/2 half bit period in clk cycles
  localparam int FILTER  = 8;
  localparam int TIMEOUT = 1000;
  localparam int DEPTH   = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        ps2_clk;
  logic        ps2_data;
  logic        rd;
  logic [31:0] data_out;
  logic        ready;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ps2_kbd_rx #(
    .FILTER  (FILTER),
    .TIMEOUT (TIMEOUT),
    .DEPTH   (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .rd       (rd),
    .data_out (data_out),
    .ready    (ready)
  );

  // Frame bits in wire order: start, data LSB first, parity, stop.
  function automatic logic [10:0] make_frame(input logic [7:0] b, input logic bad_par,
                                             input logic stop_bit);
    logic p;
    p = ~(^b) ^ bad_par;
    return {stop_bit, p, b, 1'b0};
  endfunction

  // Send the first nbits of a frame. Optionally glitch ps2_clk low for
  // 3 cycles before bit 4, or pulse rd in the cycle the stop bit's push lands.
  task automatic send(input logic [7:0] b, input logic bad_par, input logic stop_bit,
                      input int nbits, input bit glitch, input bit rd_at_stop);
    logic [10:0] f;
    f = make_frame(b, bad_par, stop_bit);
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      repeat (HALF) @(negedge clk);
      if (glitch && i == 4) begin
        ps2_clk = 1'b0;
        repeat (3) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (HALF) @(negedge clk);
      end
      ps2_clk = 1'b0;
      if (rd_at_stop && i == 10) begin
        // Fall seen after 2 sync + FILTER cycles, push one cycle after that.
        repeat (FILTER + 3) @(negedge clk);
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        repeat (HALF - FILTER - 4) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    repeat (2 * HALF) @(negedge clk);
  endtask

  task automatic pop();
    @(negedge clk);
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; rd = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (data_out !== 32'h0 || ready !== 1'b0) begin
      $display("FAIL reset_word: got data_out=%h ready=%b, want 00000000 0", data_out, ready);
      fails++;
    end
    rst = 1'b0;
    repeat (5) @(negedge clk);
    tests++;
    if (data_out !== 32'h0) begin
      $display("FAIL reset_idle: got %h, want 00000000", data_out);
      fails++;
    end
    $display("[TB] reset: data_out=%h", data_out);
  endtask

  task automatic test_clean_frame();
    send(8'h1C, 1'b0, 1'b1, 11, 1'b0, 1'b0);
    tests++;
    if (data_out !== 32'h0000_111C || ready !== 1'b1) begin
      $display("FAIL clean_1c: got %h ready=%b, want 0000111c 1", data_out, ready);
      fails++;
    end
    pop();
    tests++;
    if (data_out !== 32'h0 || ready !== 1'b0) begin
      $display("FAIL clean_pop: got %h ready=%b, want 00000000 0", data_out, ready);
      fails++;
    end
    $display("[TB] clean frame 1c: after pop %h", data_out);
  endtask

  task automatic test_errors();
    send(8'h1C, 1'b1, 1'b1, 11, 1'b0, 1'b0);
    tests++;
    if (data_out !== 32'h0000_0400) begin
      $display("FAIL parity_err: got %h, want 00000400", data_out);
      fails++;
    end
    pop();
    tests++;
    if (data_out !== 32'h0) begin
      $display("FAIL parity_clear: got %h, want 00000000", data_out);
      fails++;
    end
    send(8'h1C, 1'b0, 1'b0, 11, 1'b0, 1'b0);
    tests++;
    if (data_out !== 32'h0000_0400) begin
      $display("FAIL stop_err: got %h, want 00000400", data_out);
      fails++;
    end
    pop();
    tests++;
    if (data_out !== 32'h0) begin
      $display("FAIL stop_clear: got %h, want 00000000", data_out);
      fails++;
    end
    $display("[TB] error frames: after clear %h", data_out);
  endtask

  task automatic test_overflow();
    logic [31:0] exp;
    for (int k = 1; k <= 9; k++) begin
      send(8'(k), 1'b0, 1'b1, 11, 1'b0, 1'b0);
    end
    tests++;
    if (data_out !== 32'h0000_8301) begin
      $display("FAIL ovf_full: got %h, want 00008301", data_out);
      fails++;
    end
    for (int k = 1; k <= 8; k++) begin
      exp = {16'h0000, 4'(9 - k), 1'b0, 1'b0, (k == 1), 1'b1, 8'(k)};
      tests++;
      if (data_out !== exp) begin
        $display("FAIL ovf_read%0d: got %h, want %h", k, data_out, exp);
        fails++;
      end
      pop();
    end
    tests++;
    if (data_out !== 32'h0) begin
      $display("FAIL ovf_drained: got %h, want 00000000", data_out);
      fails++;
    end
    $display("[TB] overflow: nine frames pushed, eight read back");
  endtask

  task automatic test_push_pop_full();
    logic [31:0] exp;
    logic [7:0]  b;
    for (int k = 0; k < 8; k++) begin
      send(8'h11 + 8'(k), 1'b0, 1'b1, 11, 1'b0, 1'b0);
    end
    tests++;
    if (data_out !== 32'h0000_8111) begin
      $display("FAIL full_before: got %h, want 00008111", data_out);
      fails++;
    end
    send(8'h5A, 1'b0, 1'b1, 11, 1'b0, 1'b1);
    tests++;
    if (data_out !== 32'h0000_8112) begin
      $display("FAIL full_pushpop: got %h, want 00008112", data_out);
      fails++;
    end
    for (int j = 0; j < 8; j++) begin
      b   = (j < 7) ? 8'h12 + 8'(j) : 8'h5A;
      exp = {16'h0000, 4'(8 - j), 4'b0001, b};
      tests++;
      if (data_out !== exp) begin
        $display("FAIL full_read%0d: got %h, want %h", j, data_out, exp);
        fails++;
      end
      pop();
    end
    tests++;
    if (data_out !== 32'h0) begin
      $display("FAIL full_drained: got %h, want 00000000", data_out);
      fails++;
    end
    $display("[TB] push+pop while full: last entry 5a");
  endtask

  task automatic test_timeout();
    send(8'h33, 1'b0, 1'b1, 4, 1'b0, 1'b0);
    repeat (TIMEOUT + 10) @(negedge clk);
    send(8'h5A, 1'b0, 1'b1, 11, 1'b0, 1'b0);
    tests++;
    if (data_out !== 32'h0000_115A) begin
      $display("FAIL timeout_5a: got %h, want 0000115a", data_out);
      fails++;
    end
    pop();
    $display("[TB] timeout: partial frame dropped, 5a received");
  endtask

  task automatic test_glitch();
    send(8'hA5, 1'b0, 1'b1, 11, 1'b1, 1'b0);
    tests++;
    if (data_out !== 32'h0000_11A5) begin
      $display("FAIL glitch_a5: got %h, want 000011a5", data_out);
      fails++;
    end
    pop();
    $display("[TB] glitch: a5 received intact");
  endtask

  task automatic test_reset_midframe();
    send(8'h76, 1'b0, 1'b1, 5, 1'b0, 1'b0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if (data_out !== 32'h0) begin
      $display("FAIL midrst_word: got %h, want 00000000", data_out);
      fails++;
    end
    rst = 1'b0;
    repeat (5) @(negedge clk);
    send(8'h76, 1'b0, 1'b1, 11, 1'b0, 1'b0);
    tests++;
    if (data_out !== 32'h0000_1176) begin
      $display("FAIL midrst_76: got %h, want 00001176", data_out);
      fails++;
    end
    pop();
    $display("[TB] reset mid-frame: 76 received");
  endtask

  initial begin
    test_reset();
    test_clean_frame();
    test_errors();
    test_overflow();
    test_push_pop_full();
    test_timeout();
    test_glitch();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
